// File: rtl/rca_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rca_dispatch_scheduler
//  Purpose  : Shares NUM_RCAS reconfigurable accelerators behind a single
//             issue/writeback port pair. Each issued op goes to the RCA picked
//             by req_sel. The block tracks that RCA's busy/result state, holds
//             completed results, and round-robins them onto the one writeback
//             port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1              clock, all state on rising edge
//    rst         in   1              asynchronous active-low reset
//    req_valid   in   1              issue request
//    req_sel     in   SEL_W          target RCA index
//    req_id      in   ID_W           instruction id
//    req_ready   out  1              request accepted this cycle if req_valid
//    rca_start   out  NUM_RCAS       1-cycle start pulse per RCA
//    rca_done    in   NUM_RCAS       1-cycle completion pulse per RCA
//    rca_result  in   NUM_RCAS*XLEN  RCA results, RCA i in [i*XLEN +: XLEN]
//    wb_done     out  1              writeback valid
//    wb_id       out  ID_W           id of written-back op
//    wb_rd       out  XLEN           result data
//    wb_ack      in   1              writeback consumed
//    rca_fault   out  NUM_RCAS       sticky per-RCA timeout flag
// ============================================================================
module rca_dispatch_scheduler #(
    parameter int NUM_RCAS = 3,
    parameter int SEL_W    = 2,
    parameter int ID_W     = 3,
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [SEL_W-1:0]         req_sel,
    input  logic [ID_W-1:0]          req_id,
    output logic                     req_ready,
    output logic [NUM_RCAS-1:0]      rca_start,
    input  logic [NUM_RCAS-1:0]      rca_done,
    input  logic [NUM_RCAS*XLEN-1:0] rca_result,
    output logic                     wb_done,
    output logic [ID_W-1:0]          wb_id,
    output logic [XLEN-1:0]          wb_rd,
    input  logic                     wb_ack,
    output logic [NUM_RCAS-1:0]      rca_fault
);

    localparam int               IDX_W          = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX     = IDX_W'(NUM_RCAS - 1);
    // The slot times out on the edge where its counter would reach TIMEOUT.
    localparam logic [7:0]       C_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]       C_CNT_MAX      = 8'hFF;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_BUSY   = 2'd1,
        SLOT_RESULT = 2'd2
    } slot_state_t;

    // Per-slot status flattened for the shared request and arbiter logic
    logic [NUM_RCAS-1:0] w_sel_dec;
    logic [NUM_RCAS-1:0] w_is_idle;
    logic [NUM_RCAS-1:0] w_is_busy;
    logic [NUM_RCAS-1:0] w_is_result;
    logic [NUM_RCAS-1:0] w_pending;
    logic [ID_W-1:0]     w_slot_id  [NUM_RCAS];
    logic [XLEN-1:0]     w_slot_res [NUM_RCAS];
    logic [XLEN-1:0]     w_res_in   [NUM_RCAS];

    logic                w_accept;
    logic                w_ack;

    // Writeback register set
    logic                r_wb_done;
    logic [ID_W-1:0]     r_wb_id;
    logic [XLEN-1:0]     r_wb_rd;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_rr_ptr;

    logic                w_pick_found;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [ID_W-1:0]     w_pick_id;
    logic [XLEN-1:0]     w_pick_rd;

    // ------------------------------------------------------------------------
    // Issue side. An out-of-range req_sel matches no decode bit, so it is never
    // ready. Ready is also held low while reset is asserted. This keeps
    // rca_start quiet during reset even though every slot reads as idle.
    // ------------------------------------------------------------------------
    assign req_ready = rst & (|(w_sel_dec & w_is_idle));
    assign w_accept  = req_valid & req_ready;
    assign rca_start = {NUM_RCAS{w_accept}} & w_sel_dec;
    assign w_ack     = r_wb_done & wb_ack;

    // A done pulse on a busy slot is offered to the arbiter in the same cycle.
    // This saves a cycle of writeback latency. The result is also captured in
    // the slot, so a lost arbitration costs nothing.
    assign w_pending = w_is_result | (w_is_busy & rca_done);

    // ------------------------------------------------------------------------
    // Per-RCA slot
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RCAS; gi++) begin : g_slot
        slot_state_t      r_state;
        slot_state_t      w_state_next;
        logic [7:0]       r_cnt;
        logic [ID_W-1:0]  r_id;
        logic [XLEN-1:0]  r_res;
        logic             r_fault;
        logic             w_timeout_fire;
        logic             w_ack_hit;

        assign w_sel_dec[gi]   = (req_sel == SEL_W'(gi));
        assign w_res_in[gi]    = rca_result[gi*XLEN +: XLEN];
        assign w_ack_hit       = w_ack && (r_grant == IDX_W'(gi));

        assign w_is_idle[gi]   = (r_state == SLOT_IDLE);
        assign w_is_busy[gi]   = (r_state == SLOT_BUSY);
        assign w_is_result[gi] = (r_state == SLOT_RESULT);
        assign w_slot_id[gi]   = r_id;
        assign w_slot_res[gi]  = r_res;
        assign rca_fault[gi]   = r_fault;

        always_comb begin
            w_state_next   = r_state;
            w_timeout_fire = 1'b0;
            case (r_state)
                SLOT_IDLE: begin
                    if (rca_start[gi]) begin
                        w_state_next = SLOT_BUSY;
                    end
                end
                SLOT_BUSY: begin
                    // A completion arriving on the timeout cycle takes priority
                    if (rca_done[gi]) begin
                        w_state_next = SLOT_RESULT;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_state_next   = SLOT_IDLE;
                        w_timeout_fire = 1'b1;
                    end
                end
                SLOT_RESULT: begin
                    if (w_ack_hit) begin
                        w_state_next = SLOT_IDLE;
                    end
                end
                default: begin
                    w_state_next = SLOT_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= SLOT_IDLE;
                r_cnt   <= 8'd0;
                r_id    <= '0;
                r_res   <= '0;
                r_fault <= 1'b0;
            end else begin
                r_state <= w_state_next;
                if (rca_start[gi]) begin
                    r_id  <= req_id;
                    r_cnt <= 8'd0;
                end else if ((r_state == SLOT_BUSY) && (r_cnt != C_CNT_MAX)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if ((r_state == SLOT_BUSY) && rca_done[gi]) begin
                    r_res <= w_res_in[gi];
                end
                if (w_timeout_fire) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first pending slot at or after r_rr_ptr, wrapping
    // ------------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_RCAS) begin
            sum = sum - NUM_RCAS;
        end
        return IDX_W'(sum);
    endfunction

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 0; k < NUM_RCAS; k++) begin
            if (!w_pick_found && w_pending[wrap_idx(r_rr_ptr, k)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_pick_id = w_slot_id[w_pick_idx];
    assign w_pick_rd = w_is_result[w_pick_idx] ? w_slot_res[w_pick_idx] : w_res_in[w_pick_idx];

    // ------------------------------------------------------------------------
    // Writeback register. A new grant is only taken while wb_done is low.
    // This naturally spaces grants at least two cycles apart.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_done <= 1'b0;
            r_wb_id   <= '0;
            r_wb_rd   <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
        end else if (r_wb_done) begin
            if (wb_ack) begin
                r_wb_done <= 1'b0;
                r_rr_ptr  <= (r_grant == C_LAST_IDX) ? '0 : r_grant + 1'b1;
            end
        end else if (w_pick_found) begin
            r_wb_done <= 1'b1;
            r_grant   <= w_pick_idx;
            r_wb_id   <= w_pick_id;
            r_wb_rd   <= w_pick_rd;
        end
    end

    assign wb_done = r_wb_done;
    assign wb_id   = r_wb_id;
    assign wb_rd   = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_rca_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rca_dispatch_scheduler
//  Purpose  : Self-checking bench for rca_dispatch_scheduler. It uses a
//             directed vector table followed by hand-written multi-cycle
//             sequences. Inputs are driven on the falling edge, and outputs
//             are sampled 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rca_dispatch_scheduler;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_sel;
    logic [2:0]  req_id;
    logic        req_ready;
    logic [2:0]  rca_start;
    logic [2:0]  rca_done;
    logic [95:0] rca_result;
    logic        wb_done;
    logic [2:0]  wb_id;
    logic [31:0] wb_rd;
    logic        wb_ack;
    logic [2:0]  rca_fault;

    int cmp_cnt = 0;
    int err_cnt = 0;

    rca_dispatch_scheduler #(
        .NUM_RCAS (3),
        .SEL_W    (2),
        .ID_W     (3),
        .XLEN     (32),
        .TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .rca_start  (rca_start),
        .rca_done   (rca_done),
        .rca_result (rca_result),
        .wb_done    (wb_done),
        .wb_id      (wb_id),
        .wb_rd      (wb_rd),
        .wb_ack     (wb_ack),
        .rca_fault  (rca_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [2:0]  id;
        logic [2:0]  done;
        logic [31:0] res;
        logic        ack;
        logic        rdy;
        logic [2:0]  start;
        logic        wbd;
        logic [2:0]  wbid;
        logic [31:0] wbrd;
        logic [2:0]  fault;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [2:0] id,
                          input logic [2:0] done, input logic [31:0] res, input logic ack);
        req_valid  = v;
        req_sel    = sel;
        req_id     = id;
        rca_done   = done;
        rca_result = {3{res}};
        wb_ack     = ack;
    endtask

    task automatic chk_wb(input string name, input logic d, input logic [2:0] id, input logic [31:0] rd);
        chk({name, ".wb_done"}, 64'(wb_done), 64'(d));
        if (d) begin
            chk({name, ".wb_id"}, 64'(wb_id), 64'(id));
            chk({name, ".wb_rd"}, 64'(wb_rd), 64'(rd));
        end
    endtask

    initial begin
        // T2 single op (sel 1, id 5, done 3 cycles later), then T6 illegal cases
        tbl[0] = '{1'b1, 2'd1, 3'd5, 3'b000, 32'h0,        1'b0, 1'b1, 3'b010, 1'b0, 3'd0, 32'h0,        3'b000};
        tbl[1] = '{1'b0, 2'd1, 3'd0, 3'b000, 32'h0,        1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0,        3'b000};
        tbl[2] = '{1'b0, 2'd1, 3'd0, 3'b000, 32'h0,        1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0,        3'b000};
        tbl[3] = '{1'b0, 2'd1, 3'd0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0,        3'b000};
        tbl[4] = '{1'b0, 2'd1, 3'd0, 3'b000, 32'h0,        1'b1, 1'b0, 3'b000, 1'b1, 3'd5, 32'hDEADBEEF, 3'b000};
        tbl[5] = '{1'b0, 2'd1, 3'd0, 3'b000, 32'h0,        1'b0, 1'b1, 3'b000, 1'b0, 3'd5, 32'hDEADBEEF, 3'b000};
        tbl[6] = '{1'b1, 2'd3, 3'd2, 3'b000, 32'h0,        1'b0, 1'b0, 3'b000, 1'b0, 3'd5, 32'hDEADBEEF, 3'b000};
        tbl[7] = '{1'b0, 2'd0, 3'd0, 3'b001, 32'h12345678, 1'b0, 1'b1, 3'b000, 1'b0, 3'd5, 32'hDEADBEEF, 3'b000};
        tbl[8] = '{1'b0, 2'd0, 3'd0, 3'b000, 32'h0,        1'b0, 1'b1, 3'b000, 1'b0, 3'd5, 32'hDEADBEEF, 3'b000};

        rst = 1'b0;
        set_in(1'b1, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0);

        // Reset state: even with req_valid high, nothing may start
        @(negedge clk); #1;
        chk("rst.wb_done", 64'(wb_done), 64'd0);
        chk("rst.wb_id",   64'(wb_id),   64'd0);
        chk("rst.wb_rd",   64'(wb_rd),   64'd0);
        chk("rst.fault",   64'(rca_fault), 64'd0);
        chk("rst.start",   64'(rca_start), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            set_in(tbl[i].v, tbl[i].sel, tbl[i].id, tbl[i].done, tbl[i].res, tbl[i].ack);
            #1;
            chk($sformatf("vec%0d.ready", i), 64'(req_ready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d.start", i), 64'(rca_start), 64'(tbl[i].start));
            chk($sformatf("vec%0d.wb_done", i), 64'(wb_done), 64'(tbl[i].wbd));
            chk($sformatf("vec%0d.wb_id", i), 64'(wb_id), 64'(tbl[i].wbid));
            chk($sformatf("vec%0d.wb_rd", i), 64'(wb_rd), 64'(tbl[i].wbrd));
            chk($sformatf("vec%0d.fault", i), 64'(rca_fault), 64'(tbl[i].fault));
        end

        // ---------------- T1: reset mid-BUSY with a pending writeback ----------------
        @(negedge clk); set_in(1'b1, 2'd0, 3'd6, 3'b000, 32'h0, 1'b0); #1;
        chk("t1.start0", 64'(rca_start), 64'b001);
        @(negedge clk); set_in(1'b1, 2'd2, 3'd1, 3'b000, 32'h0, 1'b0); #1;
        chk("t1.start2", 64'(rca_start), 64'b100);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b100, 32'hAAAA5555, 1'b0);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0); #1;
        chk_wb("t1.pre", 1'b1, 3'd1, 32'hAAAA5555);
        @(negedge clk); rst = 1'b0; set_in(1'b1, 2'd1, 3'd2, 3'b000, 32'h0, 1'b0); #1;
        chk("t1.wb_done", 64'(wb_done), 64'd0);
        chk("t1.wb_id",   64'(wb_id),   64'd0);
        chk("t1.wb_rd",   64'(wb_rd),   64'd0);
        chk("t1.fault",   64'(rca_fault), 64'd0);
        chk("t1.start",   64'(rca_start), 64'd0);
        @(negedge clk); rst = 1'b1; set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            req_sel = 2'(s); #1;
            chk($sformatf("t1.ready%0d", s), 64'(req_ready), 64'd1);
        end
        // The discarded op on RCA 0 completing late must not write back
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b001, 32'h11111111, 1'b0);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0); #1;
        chk("t1.no_wb", 64'(wb_done), 64'd0);

        // ---------------- T3: round-robin, wb_ack held high ----------------
        @(negedge clk); set_in(1'b1, 2'd0, 3'd1, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b1, 2'd1, 3'd2, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b1, 2'd2, 3'd3, 3'b000, 32'h0, 1'b1); #1;
        chk("t3.start2", 64'(rca_start), 64'b100);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b111, 32'h0, 1'b1);
        rca_result = {32'h30303030, 32'h20202020, 32'h10101010};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b1); #1;
            if (k % 2 == 0)
                chk_wb($sformatf("t3.r1g%0d", k / 2), 1'b1, 3'(k / 2 + 1), {4{4'(k / 2 + 1), 4'h0}});
            else
                chk_wb($sformatf("t3.r1gap%0d", k / 2), 1'b0, 3'd0, 32'h0);
        end
        // A single op on RCA 1 moves the round-robin pointer to 2
        @(negedge clk); set_in(1'b1, 2'd1, 3'd4, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b010, 32'h40404040, 1'b1);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b1); #1;
        chk_wb("t3.mid", 1'b1, 3'd4, 32'h40404040);
        @(negedge clk); #1;
        chk_wb("t3.midgap", 1'b0, 3'd0, 32'h0);
        // Second round: RCA 2 and 0 finish together; 2 must win from rr_ptr=2
        @(negedge clk); set_in(1'b1, 2'd0, 3'd5, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b1, 2'd2, 3'd6, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b101, 32'h0, 1'b1);
        rca_result = {32'h60606060, 32'h0, 32'h50505050};
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b1); #1;
        chk_wb("t3.r2g0", 1'b1, 3'd6, 32'h60606060);
        @(negedge clk); #1;
        chk_wb("t3.r2gap", 1'b0, 3'd0, 32'h0);
        @(negedge clk); #1;
        chk_wb("t3.r2g1", 1'b1, 3'd5, 32'h50505050);
        @(negedge clk); #1;
        chk_wb("t3.r2end", 1'b0, 3'd0, 32'h0);

        // ---------------- T4: back-pressure ----------------
        @(negedge clk); set_in(1'b1, 2'd0, 3'd7, 3'b000, 32'h0, 1'b0);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b001, 32'hCAFE0001, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            case (k)
                2:       set_in(1'b1, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0);
                3:       set_in(1'b1, 2'd1, 3'd1, 3'b000, 32'h0, 1'b0);
                4:       set_in(1'b0, 2'd0, 3'd0, 3'b010, 32'hCAFE0002, 1'b0);
                default: set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0);
            endcase
            #1;
            chk_wb($sformatf("t4.hold%0d", k), 1'b1, 3'd7, 32'hCAFE0001);
            if (k == 2) begin
                chk("t4.same_ready", 64'(req_ready), 64'd0);
                chk("t4.same_start", 64'(rca_start), 64'd0);
            end
            if (k == 3) begin
                chk("t4.other_ready", 64'(req_ready), 64'd1);
                chk("t4.other_start", 64'(rca_start), 64'b010);
            end
        end
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b1); #1;
        chk_wb("t4.ackcyc", 1'b1, 3'd7, 32'hCAFE0001);
        chk("t4.ack_ready", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk_wb("t4.gap", 1'b0, 3'd0, 32'h0);
        chk("t4.idle_ready", 64'(req_ready), 64'd1);
        @(negedge clk); #1;
        chk_wb("t4.second", 1'b1, 3'd1, 32'hCAFE0002);
        @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0); #1;
        chk_wb("t4.end", 1'b0, 3'd0, 32'h0);

        // ---------------- T5: timeout (TIMEOUT = 8) ----------------
        @(negedge clk); set_in(1'b1, 2'd0, 3'd2, 3'b000, 32'h0, 1'b0); #1;
        chk("t5.start", 64'(rca_start), 64'b001);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); set_in(1'b0, 2'd0, 3'd0, 3'b000, 32'h0, 1'b0); #1;
            if (k <= 8) begin
                chk($sformatf("t5.nofault%0d", k), 64'(rca_fault), 64'b000);
            end else begin
                chk($sformatf("t5.fault%0d", k), 64'(rca_fault), 64'b001);
                chk($sformatf("t5.ready%0d", k), 64'(req_ready), 64'd1);
            end
            chk($sformatf("t5.nowb%0d", k), 64'(wb_done), 64'd0);
        end
        // Done arriving exactly on the timeout cycle wins
        @(negedge clk); set_in(1'b1, 2'd2, 3'd3, 3'b000, 32'h0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) set_in(1'b0, 2'd2, 3'd0, 3'b100, 32'h0BADF00D, 1'b0);
            else        set_in(1'b0, 2'd2, 3'd0, 3'b000, 32'h0, 1'b0);
        end
        #1;
        chk("t5.race_fault", 64'(rca_fault), 64'b001);
        chk_wb("t5.race_wb", 1'b1, 3'd3, 32'h0BADF00D);
        @(negedge clk); set_in(1'b0, 2'd2, 3'd0, 3'b000, 32'h0, 1'b1);
        @(negedge clk); set_in(1'b0, 2'd2, 3'd0, 3'b000, 32'h0, 1'b0); #1;
        chk_wb("t5.race_end", 1'b0, 3'd0, 32'h0);
        chk("t5.race_ready", 64'(req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
